// File: rtl/cruise_pkg.sv
// Shared definitions for the cruise-control command front end.
//   cmd_e         command codes presented on cmd_code
//   seq_state_e   sequencer FSM encoding exported on seq_state
//   pending bit layout: 0 brake, 1 cancel, 2 resume, 3 set, 4 accel, 5 coast
//   (bit order equals arbitration priority, lowest index wins)
package cruise_pkg;

  typedef enum logic [2:0] {
    CMD_NONE   = 3'd0,
    CMD_BRAKE  = 3'd1,
    CMD_CANCEL = 3'd2,
    CMD_RESUME = 3'd3,
    CMD_SET    = 3'd4,
    CMD_ACCEL  = 3'd5,
    CMD_COAST  = 3'd6
  } cmd_e;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    LOCKOUT = 2'd2
  } seq_state_e;

  localparam int unsigned MIN_SET_SPEED_DEF = 40;

  // Pending-bit index to command code.
  function automatic cmd_e cmd_of(input logic [2:0] idx);
    case (idx)
      3'd0:    return CMD_BRAKE;
      3'd1:    return CMD_CANCEL;
      3'd2:    return CMD_RESUME;
      3'd3:    return CMD_SET;
      3'd4:    return CMD_ACCEL;
      3'd5:    return CMD_COAST;
      default: return CMD_NONE;
    endcase
  endfunction

  // Pending bits retired when a command is accepted; an accepted brake
  // also retires a queued cancel since braking already disengages.
  function automatic logic [5:0] accept_mask(input cmd_e code);
    case (code)
      CMD_BRAKE:  return 6'b000011;
      CMD_CANCEL: return 6'b000010;
      CMD_RESUME: return 6'b000100;
      CMD_SET:    return 6'b001000;
      CMD_ACCEL:  return 6'b010000;
      CMD_COAST:  return 6'b100000;
      default:    return 6'b000000;
    endcase
  endfunction

endpackage

// File: rtl/cruise_debounce.sv
// Button debouncer: one sync flop, then the output level follows the synced
// input only after DEBOUNCE_CYCLES consecutive samples disagree with it.
//   clk, reset  clock, async active-high reset
//   btn         raw button
//   level       debounced level
//   rise        one-cycle pulse coincident with level going high
module cruise_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned CNT_W           = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  output logic level,
  output logic rise
);

  localparam int unsigned LAST = (DEBOUNCE_CYCLES > 0) ? DEBOUNCE_CYCLES - 1 : 0;

  logic             sync_q;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= 1'b0;
      level  <= 1'b0;
      rise   <= 1'b0;
      cnt    <= '0;
    end else begin
      sync_q <= btn;
      rise   <= 1'b0;
      if (sync_q == level) begin
        cnt <= '0;
      end else if (cnt >= CNT_W'(LAST)) begin
        level <= sync_q;
        rise  <= sync_q;
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/cruise_cmd_sequencer.sv
// Cruise-control command front end: debounces driver buttons, qualifies them
// against core status/speed, priority-arbitrates, and issues one command at a
// time over cmd_valid/cmd_ready.
//   clk, reset            clock, async active-high reset
//   btn_*                 raw driver switches (brake is only registered)
//   current_speed         unsigned vehicle speed
//   cruise_active         core reports cruise engaged
//   cmd_ready             core accepts cmd this cycle
//   cmd_valid / cmd_code  command handshake
//   cmd_drop              pulse: request discarded (unqualified or accel/coast clash)
//   seq_state             FSM state for debug
module cruise_cmd_sequencer
  import cruise_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned LOCKOUT_CYCLES  = 8,
  parameter int unsigned REPEAT_CYCLES   = 16,
  parameter int unsigned MIN_SET_SPEED   = MIN_SET_SPEED_DEF,
  parameter int unsigned CNT_W           = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_brake,
  input  logic       btn_cancel,
  input  logic       btn_resume,
  input  logic       btn_set,
  input  logic       btn_accel,
  input  logic       btn_coast,
  input  logic [7:0] current_speed,
  input  logic       cruise_active,
  input  logic       cmd_ready,
  output logic       cmd_valid,
  output logic [2:0] cmd_code,
  output logic       cmd_drop,
  output logic [1:0] seq_state
);

  localparam logic [7:0] MIN_SPD = 8'(MIN_SET_SPEED);

  logic [5:1] raw_btn, lvl, rise;
  logic       brake_q, brake_d, conflict, conflict_d;
  logic [5:0] pend, pend_n, clr;
  logic [1:0] rpt_fire, load_rpt;
  logic [CNT_W-1:0] rpt_accel, rpt_coast, lock_cnt, lock_n;
  seq_state_e state, state_n;
  cmd_e       code_q, code_n;
  logic       drop_n, win_vld;
  logic [2:0] win_idx;

  assign raw_btn = {btn_coast, btn_accel, btn_set, btn_resume, btn_cancel};

  for (genvar g = 1; g <= 5; g++) begin : g_dbnc
    cruise_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_dbnc (
      .clk(clk), .reset(reset), .btn(raw_btn[g]), .level(lvl[g]), .rise(rise[g])
    );
  end

  assign conflict    = lvl[4] & lvl[5];
  assign rpt_fire[0] = lvl[4] & ~conflict & (rpt_accel == CNT_W'(1));
  assign rpt_fire[1] = lvl[5] & ~conflict & (rpt_coast == CNT_W'(1));

  function automatic logic qualified(input logic [2:0] idx, input logic active,
                                     input logic [7:0] spd);
    case (idx)
      3'd0:        return 1'b1;
      3'd1, 3'd4, 3'd5: return active;
      3'd2:        return ~active && (spd >= MIN_SPD);
      3'd3:        return spd >= MIN_SPD;
      default:     return 1'b0;
    endcase
  endfunction

  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    for (int unsigned i = 0; i < 6; i++) begin
      if (pend[5-i]) begin
        win_vld = 1'b1;
        win_idx = 3'(5 - i);
      end
    end
  end

  always_comb begin
    state_n  = state;
    code_n   = code_q;
    lock_n   = lock_cnt;
    clr      = '0;
    drop_n   = 1'b0;
    load_rpt = '0;
    case (state)
      IDLE: begin
        if (win_vld) begin
          if (qualified(win_idx, cruise_active, current_speed)) begin
            state_n = ISSUE;
            code_n  = cmd_of(win_idx);
          end else begin
            clr[win_idx] = 1'b1;
            drop_n       = 1'b1;
          end
        end
      end
      ISSUE: begin
        if (cmd_ready) begin
          clr      = accept_mask(code_q);
          load_rpt = {code_q == CMD_COAST, code_q == CMD_ACCEL};
          state_n  = LOCKOUT;
          lock_n   = CNT_W'(LOCKOUT_CYCLES);
          code_n   = CMD_NONE;
        end else if (pend[0] && code_q != CMD_BRAKE) begin
          // Pre-empt the unaccepted command; its pending bit is left set.
          code_n = CMD_BRAKE;
        end
      end
      LOCKOUT: begin
        if (pend[0]) begin
          state_n = ISSUE;
          code_n  = CMD_BRAKE;
        end else if (lock_cnt <= CNT_W'(1)) begin
          state_n = IDLE;
          lock_n  = '0;
        end else begin
          lock_n = lock_cnt - 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Clear before set so an edge arriving with an accept is not lost;
  // an accel/coast clash overrides everything for those two bits.
  always_comb begin
    pend_n      = (pend & ~clr) | {rise[5:1], brake_q & ~brake_d};
    pend_n[4]   = pend_n[4] | rpt_fire[0];
    pend_n[5]   = pend_n[5] | rpt_fire[1];
    if (conflict) pend_n[5:4] = '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      brake_q    <= 1'b0;
      brake_d    <= 1'b0;
      conflict_d <= 1'b0;
      pend       <= '0;
      state      <= IDLE;
      code_q     <= CMD_NONE;
      lock_cnt   <= '0;
      cmd_drop   <= 1'b0;
      rpt_accel  <= '0;
      rpt_coast  <= '0;
    end else begin
      brake_q    <= btn_brake;
      brake_d    <= brake_q;
      conflict_d <= conflict;
      pend       <= pend_n;
      state      <= state_n;
      code_q     <= code_n;
      lock_cnt   <= lock_n;
      cmd_drop   <= drop_n | (conflict & ~conflict_d);
      if (conflict || !lvl[4])    rpt_accel <= '0;
      else if (load_rpt[0])       rpt_accel <= CNT_W'(REPEAT_CYCLES);
      else if (rpt_accel != '0)   rpt_accel <= rpt_accel - 1'b1;
      if (conflict || !lvl[5])    rpt_coast <= '0;
      else if (load_rpt[1])       rpt_coast <= CNT_W'(REPEAT_CYCLES);
      else if (rpt_coast != '0)   rpt_coast <= rpt_coast - 1'b1;
    end
  end

  assign cmd_valid = (state == ISSUE);
  assign cmd_code  = code_q;
  assign seq_state = state;

endmodule
